// File: rtl/auth_pkg.sv
// auth_pkg
// Shared types and constants for the ride authorization sequencer.
//   auth_state_t : sequencer state encoding, also exported on the debug
//                  state_o port when AUTH_STATUS_EN is defined.
//   CMD_G/CMD_S  : default power-up ('G') and stop ('S') command bytes.
package auth_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      PWR1   = 2'd2,
      PWR2   = 2'd3
   } auth_state_t;

   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] CMD_S = 8'h53;

endpackage

// File: rtl/auth_tmr.sv
// auth_tmr
// Loadable down-counter that stops at zero instead of wrapping.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset, clears the count
//   ld     : load ld_val (takes priority over en)
//   ld_val : value to load
//   en     : decrement by one while the count is non-zero
//   zero   : high while the count is zero
module auth_tmr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   // Load wins over decrement; once the count reaches zero it holds there
   // so a long enable never wraps back to the top of the range.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (ld) begin
         cnt <= ld_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/auth_seq_blk.sv
// auth_seq_blk
// Ride authorization sequencer. Watches bytes from the BLE UART receiver and
// raises pwr_up only after a multi-byte passcode followed by the GO command.
// Repeated bad bytes lock the block out for LOCK_CYC cycles, and a rider that
// stays off the platform for OFF_TMO cycles while powered forces power-down.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rx_rdy     : UART receiver has a byte available
//   rx_data    : received byte
//   rider_off  : rider is off the platform
//   pwr_up     : enables the balance controller
//   clr_rx_rdy : one-cycle pulse clearing the receiver's ready flag
//   locked     : high during the failed-attempt lockout
// Optional (macro AUTH_STATUS_EN):
//   state_o    : current state, auth_state_t encoding
//   fail_cnt_o : consecutive bad-byte count
module auth_seq_blk
   import auth_pkg::*;
#(
   parameter int                    CODE_LEN = 2,
   parameter logic [8*CODE_LEN-1:0] CODE     = 16'h3137,
   parameter logic [7:0]            GO_CMD   = CMD_G,
   parameter logic [7:0]            STOP_CMD = CMD_S,
   parameter int                    MAX_FAIL = 3,
   parameter int                    LOCK_CYC = 50_000_000,
   parameter int                    OFF_TMO  = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   input  logic       rider_off,
   output logic       pwr_up,
   output logic       clr_rx_rdy,
   output logic       locked
`ifdef AUTH_STATUS_EN
   ,
   output logic [1:0]                    state_o,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt_o
`endif
);

   localparam int IW = $clog2(CODE_LEN + 1);
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam int LW = $clog2(LOCK_CYC + 1);
   localparam int OW = $clog2(OFF_TMO + 1);

   // The entry edge itself counts as the first cycle of each timed interval,
   // so the timers are loaded one short and the exit happens on the edge
   // where the timer is already sitting at zero.
   localparam logic [LW-1:0] LOCK_LD    = LW'(LOCK_CYC - 1);
   localparam logic [OW-1:0] OFF_LD     = OW'(OFF_TMO - 1);
   localparam logic [IW-1:0] IDX_END    = IW'(CODE_LEN);
   localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);
   localparam logic [7:0]    CODE_FIRST = 8'(CODE >> (8 * (CODE_LEN - 1)));

   auth_state_t   state;
   auth_state_t   state_n;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_n;
   logic [FW-1:0] fail_cnt;
   logic [FW-1:0] fail_n;
   logic [7:0]    code_byte;
   logic          accept;
   logic          lock_ld;
   logic          lock_en;
   logic          lock_zero;
   logic          off_ld;
   logic          off_en;
   logic          off_zero;

   // A byte is taken only when the clear pulse is not already in flight, so
   // the ready flag still high from the previous byte is never reprocessed.
   assign accept = rx_rdy && !clr_rx_rdy;

   // Select the passcode byte expected at the current position, first byte
   // in the most significant slot of CODE.
   always_comb begin
      code_byte = CODE_FIRST;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (idx == IW'(i)) begin
            code_byte = 8'(CODE >> (8 * (CODE_LEN - 1 - i)));
         end
      end
   end

   // Next-state and bookkeeping. A bad byte that happens to be the first
   // passcode byte restarts the passcode at position one rather than zero,
   // so a retyped code after a slip still works. STOP is always harmless
   // while idle.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      fail_n  = fail_cnt;
      lock_ld = 1'b0;
      case (state)
         IDLE: begin
            if (accept && (rx_data != STOP_CMD)) begin
               if ((idx != IDX_END) && (rx_data == code_byte)) begin
                  idx_n = idx + IW'(1);
               end else if ((idx == IDX_END) && (rx_data == GO_CMD)) begin
                  state_n = PWR1;
                  idx_n   = '0;
                  fail_n  = '0;
               end else begin
                  fail_n = fail_cnt + FW'(1);
                  idx_n  = (rx_data == CODE_FIRST) ? IW'(1) : '0;
                  if (fail_n == FAIL_MAX) begin
                     state_n = LOCKED;
                     lock_ld = 1'b1;
                  end
               end
            end
         end
         LOCKED: begin
            if (lock_zero) begin
               state_n = IDLE;
               idx_n   = '0;
               fail_n  = '0;
            end
         end
         PWR1: begin
            if (rider_off && off_zero) begin
               state_n = IDLE;
               idx_n   = '0;
            end else if (accept && (rx_data == STOP_CMD)) begin
               state_n = rider_off ? IDLE : PWR2;
               idx_n   = '0;
            end
         end
         PWR2: begin
            if (rider_off) begin
               state_n = IDLE;
               idx_n   = '0;
            end else if (accept && (rx_data == GO_CMD)) begin
               state_n = PWR1;
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
         end
      endcase
   end

   // The lockout timer runs only while locked. The off timer is held at its
   // reload value unless the rider is off in PWR1, so any rider_off=0 cycle
   // or any visit to another state restarts the count.
   assign lock_en = (state == LOCKED);
   assign off_en  = (state == PWR1) && rider_off;
   assign off_ld  = !off_en;

   auth_tmr #(.WIDTH(LW)) u_lock_tmr (
      .clk    (clk),
      .rst    (rst),
      .ld     (lock_ld),
      .ld_val (LOCK_LD),
      .en     (lock_en),
      .zero   (lock_zero)
   );

   auth_tmr #(.WIDTH(OW)) u_off_tmr (
      .clk    (clk),
      .rst    (rst),
      .ld     (off_ld),
      .ld_val (OFF_LD),
      .en     (off_en),
      .zero   (off_zero)
   );

   // State register plus registered outputs. Outputs are decoded from the
   // next state so they change on the same edge as the state does.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         fail_cnt   <= '0;
         pwr_up     <= 1'b0;
         locked     <= 1'b0;
         clr_rx_rdy <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         fail_cnt   <= fail_n;
         pwr_up     <= (state_n == PWR1) || (state_n == PWR2);
         locked     <= (state_n == LOCKED);
         clr_rx_rdy <= accept;
      end
   end

`ifdef AUTH_STATUS_EN
   // Debug view straight off the state and fail-count registers.
   assign state_o    = state;
   assign fail_cnt_o = fail_cnt;
`endif

endmodule

// File: tb/tb_auth_seq_blk.sv
// tb_auth_seq_blk
// Self-checking bench for auth_seq_blk with CODE=16'h3137, MAX_FAIL=3,
// LOCK_CYC=100, OFF_TMO=200. Directed scenarios check fixed expectations;
// a randomized phase compares every cycle against a behavioural model.
// Define AUTH_STATUS_EN to also exercise the debug ports.
module tb_auth_seq_blk;

   localparam int         LOCK_CYC = 100;
   localparam int         OFF_TMO  = 200;
   localparam int         MAX_FAIL = 3;
   localparam logic [7:0] B1 = 8'h31;
   localparam logic [7:0] B7 = 8'h37;
   localparam logic [7:0] BG = 8'h47;
   localparam logic [7:0] BS = 8'h53;

   localparam int MD_IDLE = 0;
   localparam int MD_LOCK = 1;
   localparam int MD_RUN  = 2;
   localparam int MD_PARK = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rider_off = 1'b0;
   logic       pwr_up;
   logic       clr_rx_rdy;
   logic       locked;
`ifdef AUTH_STATUS_EN
   logic [1:0] state_o;
   logic [1:0] fail_cnt_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] code_q [2] = '{8'h31, 8'h37};
   int m_mode = MD_IDLE;
   int m_prog = 0;
   int m_fails = 0;
   int m_lock_until = 0;
   int m_run = 0;
   int cyc = 0;
   bit m_clr = 1'b0;
   bit m_pwr = 1'b0;
   bit m_lock = 1'b0;
   int lock_seen = 0;

   auth_seq_blk #(
      .CODE_LEN (2),
      .CODE     (16'h3137),
      .MAX_FAIL (MAX_FAIL),
      .LOCK_CYC (LOCK_CYC),
      .OFF_TMO  (OFF_TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .rider_off  (rider_off),
      .pwr_up     (pwr_up),
      .clr_rx_rdy (clr_rx_rdy),
      .locked     (locked)
`ifdef AUTH_STATUS_EN
      ,
      .state_o    (state_o),
      .fail_cnt_o (fail_cnt_o)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout want $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Behavioural reference, advanced once per rising edge. Lockout is kept as
   // an absolute release cycle and the off timeout as a run length of
   // consecutive rider_off cycles while powered.
   task automatic model_step();
      bit acc;
      cyc++;
      if (rst) begin
         m_mode  = MD_IDLE;
         m_prog  = 0;
         m_fails = 0;
         m_run   = 0;
         m_clr   = 1'b0;
      end else begin
         acc   = rx_rdy && !m_clr;
         m_clr = acc;
         case (m_mode)
            MD_LOCK: begin
               if (cyc >= m_lock_until) begin
                  m_mode  = MD_IDLE;
                  m_prog  = 0;
                  m_fails = 0;
               end
            end
            MD_IDLE: begin
               if (acc && rx_data != BS) begin
                  if (m_prog < 2 && rx_data == code_q[m_prog]) begin
                     m_prog++;
                  end else if (m_prog == 2 && rx_data == BG) begin
                     m_mode  = MD_RUN;
                     m_prog  = 0;
                     m_fails = 0;
                  end else begin
                     m_fails++;
                     m_prog = (rx_data == code_q[0]) ? 1 : 0;
                     if (m_fails == MAX_FAIL) begin
                        m_mode       = MD_LOCK;
                        m_lock_until = cyc + LOCK_CYC;
                     end
                  end
               end
            end
            MD_RUN: begin
               m_run = rider_off ? m_run + 1 : 0;
               if (m_run >= OFF_TMO) m_mode = MD_IDLE;
               else if (acc && rx_data == BS) m_mode = rider_off ? MD_IDLE : MD_PARK;
            end
            MD_PARK: begin
               if (rider_off) m_mode = MD_IDLE;
               else if (acc && rx_data == BG) m_mode = MD_RUN;
            end
            default: m_mode = MD_IDLE;
         endcase
         if (m_mode != MD_RUN) m_run = 0;
         if (m_mode == MD_IDLE && m_prog == 0 && m_fails == 0) m_prog = 0;
      end
      m_pwr  = (m_mode == MD_RUN) || (m_mode == MD_PARK);
      m_lock = (m_mode == MD_LOCK);
   endtask

   // One clock: advance the model at the edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (locked === 1'b1) lock_seen++;
   endtask

   // Present one byte the way the UART does: ready stays high through the
   // clear-pulse cycle, then drops. Reports the outputs just after the
   // accepting edge and the number of clear pulses seen.
   task automatic applyStimulus(input logic [7:0] b, output int pulses,
                                output logic pwr1, output logic lock1);
      pulses  = 0;
      rx_data = b;
      rx_rdy  = 1'b1;
      tick();
      pwr1  = pwr_up;
      lock1 = locked;
      if (clr_rx_rdy === 1'b1) pulses++;
      tick();
      if (clr_rx_rdy === 1'b1) pulses++;
      rx_rdy = 1'b0;
      tick();
      if (clr_rx_rdy === 1'b1) pulses++;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      rx_rdy = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Outputs after reset.
   task automatic test_reset();
      rst       = 1'b1;
      rx_rdy    = 1'b0;
      rider_off = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (pwr_up !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pwr_up: got %b want 0", pwr_up); end
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
      n_cmp++;
      if (clr_rx_rdy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_clr: got %b want 0", clr_rx_rdy); end
`ifdef AUTH_STATUS_EN
      n_cmp++;
      if (state_o !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_state_o: got %0d want 0", state_o); end
      n_cmp++;
      if (fail_cnt_o !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_fail_cnt_o: got %0d want 0", fail_cnt_o); end
`endif
      rst = 1'b0;
      tick();
   endtask

   // Lone GO does nothing; passcode then GO powers up one cycle after accept.
   task automatic test_passcode();
      int   p;
      logic pw;
      logic lk;
      applyStimulus(BG, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b0) begin n_bad++; $display("[TB] FAIL lone_go_pwr: got %b want 0", pw); end
      n_cmp++;
      if (p != 1) begin n_bad++; $display("[TB] FAIL lone_go_clr_pulses: got %0d want 1", p); end
      applyStimulus(B1, p, pw, lk);
      n_cmp++;
      if (p != 1) begin n_bad++; $display("[TB] FAIL code1_clr_pulses: got %0d want 1", p); end
      applyStimulus(B7, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b0) begin n_bad++; $display("[TB] FAIL pre_go_pwr: got %b want 0", pw); end
      applyStimulus(BG, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b1) begin n_bad++; $display("[TB] FAIL go_pwr_up: got %b want 1", pw); end
      n_cmp++;
      if (p != 1) begin n_bad++; $display("[TB] FAIL go_clr_pulses: got %0d want 1", p); end
`ifdef AUTH_STATUS_EN
      n_cmp++;
      if (state_o !== 2'd2) begin n_bad++; $display("[TB] FAIL go_state_o: got %0d want 2", state_o); end
      n_cmp++;
      if (fail_cnt_o !== 2'd0) begin n_bad++; $display("[TB] FAIL go_fail_cnt_o: got %0d want 0", fail_cnt_o); end
`endif
   endtask

   // Three bad bytes lock out for exactly LOCK_CYC cycles; code is ignored
   // while locked and works again afterwards.
   task automatic test_lockout();
      int   p;
      logic pw;
      logic lk;
      do_reset();
      applyStimulus(8'h58, p, pw, lk);
      applyStimulus(8'h59, p, pw, lk);
      n_cmp++;
      if (lk !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_after_y: got %b want 0", lk); end
      lock_seen = 0;
      applyStimulus(8'h5A, p, pw, lk);
      n_cmp++;
      if (lk !== 1'b1) begin n_bad++; $display("[TB] FAIL lock_after_z: got %b want 1", lk); end
      applyStimulus(B1, p, pw, lk);
      applyStimulus(B7, p, pw, lk);
      applyStimulus(BG, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_ignores_code: got %b want 0", pw); end
      for (int i = 0; i < 300 && locked === 1'b1; i++) tick();
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_release: got %b want 0", locked); end
      n_cmp++;
      if (lock_seen != LOCK_CYC) begin n_bad++; $display("[TB] FAIL lock_duration: got %0d want %0d", lock_seen, LOCK_CYC); end
      applyStimulus(B1, p, pw, lk);
      applyStimulus(B7, p, pw, lk);
      applyStimulus(BG, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b1) begin n_bad++; $display("[TB] FAIL unlock_code_go: got %b want 1", pw); end
   endtask

   // STOP with rider on parks in PWR2; rider leaving then drops power.
   task automatic test_stop_park();
      int   p;
      logic pw;
      logic lk;
      rider_off = 1'b0;
      applyStimulus(BS, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b1) begin n_bad++; $display("[TB] FAIL stop_park_pwr: got %b want 1", pw); end
`ifdef AUTH_STATUS_EN
      n_cmp++;
      if (state_o !== 2'd3) begin n_bad++; $display("[TB] FAIL stop_park_state_o: got %0d want 3", state_o); end
`endif
      rider_off = 1'b1;
      tick();
      n_cmp++;
      if (pwr_up !== 1'b0) begin n_bad++; $display("[TB] FAIL park_rider_off: got %b want 0", pwr_up); end
      rider_off = 1'b0;
      tick();
   endtask

   // GO from PWR2 resumes without passcode; off timeout boundary at 199/200
   // and a single rider_off=0 cycle restarting the count.
   task automatic test_resume_timeout();
      int   p;
      logic pw;
      logic lk;
      applyStimulus(B1, p, pw, lk);
      applyStimulus(B7, p, pw, lk);
      applyStimulus(BG, p, pw, lk);
      applyStimulus(BS, p, pw, lk);
      applyStimulus(BG, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b1) begin n_bad++; $display("[TB] FAIL resume_go_pwr: got %b want 1", pw); end
      rider_off = 1'b1;
      repeat (OFF_TMO - 1) tick();
      n_cmp++;
      if (pwr_up !== 1'b1) begin n_bad++; $display("[TB] FAIL off_199: got %b want 1", pwr_up); end
      rider_off = 1'b0;
      tick();
      rider_off = 1'b1;
      repeat (OFF_TMO - 1) tick();
      n_cmp++;
      if (pwr_up !== 1'b1) begin n_bad++; $display("[TB] FAIL off_glitch_restart: got %b want 1", pwr_up); end
      tick();
      n_cmp++;
      if (pwr_up !== 1'b0) begin n_bad++; $display("[TB] FAIL off_200: got %b want 0", pwr_up); end
      rider_off = 1'b0;
      tick();
   endtask

   // Reset mid-passcode and while powered clears progress and outputs.
   task automatic test_reset_mid();
      int   p;
      logic pw;
      logic lk;
      do_reset();
      applyStimulus(B1, p, pw, lk);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(B7, p, pw, lk);
      applyStimulus(BG, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_clears_idx: got %b want 0", pw); end
      do_reset();
      applyStimulus(B1, p, pw, lk);
      applyStimulus(B7, p, pw, lk);
      applyStimulus(BG, p, pw, lk);
      rx_data = B1;
      rx_rdy  = 1'b1;
      rst     = 1'b1;
      tick();
      n_cmp++;
      if (pwr_up !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_pwr1_pwr_up: got %b want 0", pwr_up); end
      n_cmp++;
      if (clr_rx_rdy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_pwr1_clr: got %b want 0", clr_rx_rdy); end
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_pwr1_locked: got %b want 0", locked); end
      rst    = 1'b0;
      rx_rdy = 1'b0;
      tick();
      applyStimulus(B7, p, pw, lk);
      applyStimulus(BG, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_pwr1_then_code: got %b want 0", pw); end
   endtask

   // A repeated first byte is a fail that keeps position one armed.
   task automatic test_rearm();
      int   p;
      logic pw;
      logic lk;
      do_reset();
      applyStimulus(B1, p, pw, lk);
      applyStimulus(B1, p, pw, lk);
`ifdef AUTH_STATUS_EN
      n_cmp++;
      if (fail_cnt_o !== 2'd1) begin n_bad++; $display("[TB] FAIL rearm_fail_one: got %0d want 1", fail_cnt_o); end
`endif
      applyStimulus(B7, p, pw, lk);
      applyStimulus(BG, p, pw, lk);
      n_cmp++;
      if (pw !== 1'b1) begin n_bad++; $display("[TB] FAIL rearm_pwr: got %b want 1", pw); end
`ifdef AUTH_STATUS_EN
      n_cmp++;
      if (fail_cnt_o !== 2'd0) begin n_bad++; $display("[TB] FAIL rearm_fail_zero: got %0d want 0", fail_cnt_o); end
`endif
   endtask

   // Random byte traffic, rider movement and occasional resets, compared
   // against the reference model every cycle.
   task automatic test_random();
      int r;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (rx_rdy && clr_rx_rdy) begin
            rx_rdy = 1'b0;
         end else if (!rx_rdy && $urandom_range(3) == 0) begin
            r = $urandom_range(9);
            if (r < 4) rx_data = B1;
            else if (r < 6) rx_data = B7;
            else if (r < 8) rx_data = BG;
            else if (r == 8) rx_data = BS;
            else rx_data = 8'($urandom);
            rx_rdy = 1'b1;
         end
         if ($urandom_range(149) == 0) rider_off = ~rider_off;
         rst = ($urandom_range(1999) == 0);
         tick();
         n_cmp++;
         if (pwr_up !== m_pwr) begin n_bad++; $display("[TB] FAIL rand_pwr_up cyc %0d: got %b want %b", cyc, pwr_up, m_pwr); end
         n_cmp++;
         if (locked !== m_lock) begin n_bad++; $display("[TB] FAIL rand_locked cyc %0d: got %b want %b", cyc, locked, m_lock); end
         n_cmp++;
         if (clr_rx_rdy !== m_clr) begin n_bad++; $display("[TB] FAIL rand_clr cyc %0d: got %b want %b", cyc, clr_rx_rdy, m_clr); end
`ifdef AUTH_STATUS_EN
         n_cmp++;
         if (state_o !== 2'(m_mode)) begin n_bad++; $display("[TB] FAIL rand_state_o cyc %0d: got %0d want %0d", cyc, state_o, m_mode); end
         n_cmp++;
         if (fail_cnt_o !== 2'(m_fails)) begin n_bad++; $display("[TB] FAIL rand_fail_cnt_o cyc %0d: got %0d want %0d", cyc, fail_cnt_o, m_fails); end
`endif
      end
      rst       = 1'b0;
      rx_rdy    = 1'b0;
      rider_off = 1'b0;
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_passcode();
      test_lockout();
      test_stop_park();
      test_resume_timeout();
      test_reset_mid();
      test_rearm();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
